alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU (ADD/SUB/MUL) between two requesters (req0, req1) using valid/ready handshakes.
- Arbitrates round-robin and latches the winning operation.
- Holds the ALU inputs stable for the operation's cycle count (MUL is a multicycle path), then returns the result to the requester that issued it.
- Sits between the execute-stage issue logic and the ALU instance.

Parameters:
MUL_CYCLES, 4, cycles the ALU inputs are held for OP_MUL (legal range 1..15)
ADDSUB_CYCLES, 1, cycles the ALU inputs are held for OP_ADD/OP_SUB (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_opcode  in  7  requester 0 opcode (OP_ADD/OP_SUB/OP_MUL from the shared parameters file)
req0_a  in  32  requester 0 operand A
req0_b  in  32  requester 0 operand B
resp0_valid  out  1  result for requester 0 available
resp0_ready  in  1  requester 0 consumes result
resp0_result  out  32  result
resp0_equal  out  1  A==B flag from ALU
resp0_illegal  out  1  opcode was not ADD/SUB/MUL
req1_* / resp1_*  same widths and meaning as requester 0
alu_opcode  out  7  to ALU opcode
alu_a  out  32  to ALU operand A
alu_b  out  32  to ALU operand B
alu_result  in  32  from ALU result
alu_equal  in  1  from ALU equal
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, priority pointer=0 (req0 favoured).
  - All outputs 0, including the ALU drive, resp registers and ready signals.
- States are IDLE, EXEC and RESP.
- IDLE:
  - Grant:
    - Only one valid: it wins.
    - Both valid: the pointer's requester wins.
    - ready of the winner is asserted combinationally in the same cycle (ready may depend on valid).
    - The loser's ready is 0.
  - On the handshake edge:
    - Latch opcode/A/B and the grant id.
    - Load the counter: MUL -> MUL_CYCLES; ADD/SUB -> ADDSUB_CYCLES; any other opcode -> 1.
    - Next state EXEC.
  - No valid: stay in IDLE; alu_* driven to 0.
- EXEC:
  - alu_opcode/alu_a/alu_b are driven from the latched registers and stay stable every EXEC cycle.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, on the clock edge:
    - Capture alu_result/alu_equal into the granted requester's resp registers.
    - illegal opcode: capture result=0, equal=0, illegal=1.
    - Next state RESP.
  - Requester inputs are ignored during EXEC; both req_ready are 0.
- RESP:
  - respX_valid=1 for the granted requester only; the other resp_valid stays 0.
  - Result, equal and illegal are held until respX_ready=1.
  - On the handshake edge:
    - resp_valid drops to 0.
    - Pointer moves to the non-granted requester.
    - Next state IDLE.
  - alu_* keep the latched values during RESP.
- Latency, measured from the request handshake edge: resp_valid rises N edges later (N = cycle count of the opcode), e.g. ADD -> resp_valid visible 1 cycle after accept.
- Throughput: at most one operation in flight; back-to-back minimum of N+2 cycles per operation with resp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Requesters must hold valid and payload stable until ready; the arbiter samples only on the handshake.
- A requester deasserting valid before grant is legal; it is simply not granted.
- Arithmetic: width rules belong to the ALU (32-bit wrap for ADD/SUB, low 32 bits for MUL); the arbiter passes values unmodified.
- Reset mid-operation (EXEC or RESP): in-flight operation is discarded; no response is ever produced for it; pointer returns to 0.
- resp registers keep their last value after the handshake, but are only meaningful while resp_valid=1.

Test Plan:
- Single ADD:
  - Stimulus: req0 with A=0x0000_0005, B=0x0000_0003.
  - Response: req0_ready same cycle; resp0_valid 1 cycle later with result=0x0000_0008, equal=0, illegal=0; resp1_valid stays 0.
- MUL multicycle, MUL_CYCLES=4:
  - Stimulus: req1 MUL with A=0x0001_0000, B=0x0001_0000.
  - Response: alu_a/alu_b stable for 4 EXEC cycles; resp1_valid 4 cycles after accept with result=0x0000_0000 (low 32 bits); busy high throughout.
- Contention:
  - Stimulus: both requesters valid from reset with SUB 10-3 (req0) and SUB 3-10 (req1); resp_ready tied 1.
  - Response: req0 served first (result 0x0000_0007), then req1 (result 0xFFFF_FFF9); next pair served req1's turn skipped only if req1 invalid; grants alternate over 6 operations.
- Backpressure and equality:
  - Stimulus: ADD A=B=0x1234_5678 with resp0_ready held 0 for 5 cycles.
  - Response: resp0_valid, resp0_result=0x2468_ACF0 and resp0_equal=1 held stable; no new grant until the handshake; req1_ready stays 0.
- Illegal opcode:
  - Stimulus: opcode 7'h7F.
  - Response: 1 EXEC cycle, then resp_valid with illegal=1, result=0, equal=0.
- Mid-operation reset:
  - Stimulus: rst_n pulsed low during EXEC of a MUL.
  - Response: all outputs 0 immediately (async); no resp_valid afterwards; next simultaneous request grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latches the winning operation, holds ALU inputs for the op's cycle count, then returns the result.
//
// state | meaning
// IDLE  | waiting for a request; ALU inputs driven to 0
// EXEC  | latched op on the ALU, counting down the multicycle hold
// RESP  | result held for the granted requester until it is consumed
module alu_arbiter #(
  parameter int MUL_CYCLES    = 4,
  parameter int ADDSUB_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [6:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic        resp0_equal,
  output logic        resp0_illegal,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [6:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic        resp1_equal,
  output logic        resp1_illegal,
  output logic [6:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_equal,
  output logic        busy
);

  localparam logic [6:0] OP_ADD = 7'h01;
  localparam logic [6:0] OP_SUB = 7'h02;
  localparam logic [6:0] OP_MUL = 7'h03;

  localparam logic [3:0] MUL_CNT    = 4'(MUL_CYCLES);
  localparam logic [3:0] ADDSUB_CNT = 4'(ADDSUB_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        ptr;
  logic        grant_id;
  logic        win_valid;
  logic        win_id;
  logic        accept;
  logic        done;
  logic        resp_hs;

  logic [6:0]  sel_opcode;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_illegal;
  logic [3:0]  sel_count;

  logic [6:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        illegal_q;
  logic [3:0]  count;

  logic [31:0] cap_result;
  logic        cap_equal;

  // Winner selection: a lone valid wins outright, the pointer only breaks ties.
  always_comb begin
    win_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) win_id = ptr;
    else                          win_id = req1_valid;

    sel_opcode = win_id ? req1_opcode : req0_opcode;
    sel_a      = win_id ? req1_a      : req0_a;
    sel_b      = win_id ? req1_b      : req0_b;

    case (sel_opcode)
      OP_MUL: begin
        sel_count   = MUL_CNT;
        sel_illegal = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        sel_count   = ADDSUB_CNT;
        sel_illegal = 1'b0;
      end
      default: begin
        sel_count   = 4'd1;
        sel_illegal = 1'b1;
      end
    endcase
  end

  // rst_n gates the grant so ready stays low while reset is held.
  assign accept  = rst_n && (state == IDLE) && win_valid;
  assign done    = (state == EXEC) && (count == 4'd1);
  assign resp_hs = (state == RESP) && (grant_id ? resp1_ready : resp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:    if (done)    state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_opcode  = '0;
    alu_a       = '0;
    alu_b       = '0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = accept & ~win_id;
        req1_ready = accept & win_id;
      end
      EXEC: begin
        busy       = 1'b1;
        alu_opcode = op_q;
        alu_a      = a_q;
        alu_b      = b_q;
      end
      RESP: begin
        busy        = 1'b1;
        alu_opcode  = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        resp0_valid = ~grant_id;
        resp1_valid = grant_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      grant_id  <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
      count     <= '0;
    end else begin
      if (accept) begin
        grant_id  <= win_id;
        op_q      <= sel_opcode;
        a_q       <= sel_a;
        b_q       <= sel_b;
        illegal_q <= sel_illegal;
        count     <= sel_count;
      end else if ((state == EXEC) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if (resp_hs) ptr <= ~grant_id;
    end
  end

  // An illegal opcode never trusts the ALU: result and equal are forced low.
  assign cap_result = illegal_q ? 32'd0 : alu_result;
  assign cap_equal  = ~illegal_q & alu_equal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_result  <= '0;
      resp0_equal   <= 1'b0;
      resp0_illegal <= 1'b0;
      resp1_result  <= '0;
      resp1_equal   <= 1'b0;
      resp1_illegal <= 1'b0;
    end else if (done) begin
      if (grant_id) begin
        resp1_result  <= cap_result;
        resp1_equal   <= cap_equal;
        resp1_illegal <= illegal_q;
      end else begin
        resp0_result  <= cap_result;
        resp0_equal   <= cap_equal;
        resp0_illegal <= illegal_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, scoreboard of expected responses,
// directed sequences for contention, multicycle MUL, backpressure, illegal opcode and mid-op reset.
module tb_alu_arbiter;

  localparam int MUL_CYCLES    = 4;
  localparam int ADDSUB_CYCLES = 1;

  localparam logic [6:0] OP_ADD = 7'h01;
  localparam logic [6:0] OP_SUB = 7'h02;
  localparam logic [6:0] OP_MUL = 7'h03;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_equal, resp0_illegal;
  logic [6:0]  req0_opcode;
  logic [31:0] req0_a, req0_b, resp0_result;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_equal, resp1_illegal;
  logic [6:0]  req1_opcode;
  logic [31:0] req1_a, req1_b, resp1_result;
  logic [6:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_equal;
  logic        busy;

  alu_arbiter #(
    .MUL_CYCLES   (MUL_CYCLES),
    .ADDSUB_CYCLES(ADDSUB_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_opcode  (req0_opcode),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .resp0_equal  (resp0_equal),
    .resp0_illegal(resp0_illegal),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_opcode  (req1_opcode),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .resp1_equal  (resp1_equal),
    .resp1_illegal(resp1_illegal),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_equal    (alu_equal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown opcodes return a poison value the arbiter must mask.
  always_comb begin
    alu_equal = (alu_a == alu_b);
    case (alu_opcode)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_MUL:  alu_result = alu_a * alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    bit          id;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          eq;
    bit          ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t     sb[$];
  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;
  bit [1:0] prev_rv = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit id, input logic [6:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id  = id;
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.eq  = (a == b);
    e.ill = 1'b0;
    e.acc = 0;
    case (op)
      OP_ADD: begin e.res = a + b; e.lat = ADDSUB_CYCLES; end
      OP_SUB: begin e.res = a - b; e.lat = ADDSUB_CYCLES; end
      OP_MUL: begin e.res = a * b; e.lat = MUL_CYCLES;    end
      default: begin
        e.res = 32'd0;
        e.eq  = 1'b0;
        e.ill = 1'b1;
        e.lat = 1;
      end
    endcase
    return e;
  endfunction

  task automatic push_exp(input bit id, input logic [6:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(id, op, a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check_resp(input bit id, input logic rv, input logic rr,
                            input logic [31:0] res, input logic eq, input logic ill);
    if (rv) begin
      if (sb.size() == 0 || sb[0].id != id) begin
        chk(id ? "resp1_spurious" : "resp0_spurious", 32'(rv), 32'd0);
      end else begin
        if (!prev_rv[id]) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        chk(id ? "resp1_result" : "resp0_result", res, sb[0].res);
        chk(id ? "resp1_equal" : "resp0_equal", 32'(eq), 32'(sb[0].eq));
        chk(id ? "resp1_illegal" : "resp0_illegal", 32'(ill), 32'(sb[0].ill));
        if (rr) void'(sb.pop_front());
      end
    end
    prev_rv[id] = rv;
  endtask

  // One cycle: sample everything at the falling edge, then return just after the next rising edge.
  task automatic tick(output logic acc0, output logic acc1);
    @(negedge clk);
    cyc++;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("alu_opcode_held", 32'(alu_opcode), 32'(sb[0].op));
        chk("alu_a_held", alu_a, sb[0].a);
        chk("alu_b_held", alu_b, sb[0].b);
      end else begin
        chk("alu_a_idle", alu_a, 32'd0);
        chk("alu_opcode_idle", 32'(alu_opcode), 32'd0);
      end
      check_resp(1'b0, resp0_valid, resp0_ready, resp0_result, resp0_equal, resp0_illegal);
      check_resp(1'b1, resp1_valid, resp1_ready, resp1_result, resp1_equal, resp1_illegal);
      if (req0_valid && req1_valid) chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) begin
        push_exp(1'b0, req0_opcode, req0_a, req0_b);
        acc0 = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        push_exp(1'b1, req1_opcode, req1_a, req1_b);
        acc1 = 1'b1;
      end
    end else begin
      prev_rv = 2'b00;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [6:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit now);
    logic a0, a1;
    int   n;
    if (id) begin
      req1_opcode = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_opcode = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    tick(a0, a1);
    n = 1;
    if (now) chk("ready_same_cycle", 32'(id ? a1 : a0), 32'd1);
    while (!(id ? a1 : a0) && n < 50) begin
      tick(a0, a1);
      n++;
    end
    if (!(id ? a1 : a0)) chk("send_timeout", 32'(n), 32'd0);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic grant_wait(output logic a0, output logic a1);
    int n;
    n  = 0;
    a0 = 1'b0;
    a1 = 1'b0;
    while (!(a0 || a1) && n < 50) begin
      tick(a0, a1);
      n++;
    end
    if (!(a0 || a1)) chk("grant_timeout", 32'(n), 32'd0);
  endtask

  task automatic drain();
    logic a0, a1;
    int   n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      tick(a0, a1);
      n++;
    end
    if (sb.size() != 0 || busy) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero();
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_resp1_result", resp1_result, 32'd0);
    chk("rst_resp0_illegal", 32'(resp0_illegal), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1;
    int   ops, guard, last_acc;
    bit   expect_id;

    // Both requesters valid from reset with SUB 10-3 and SUB 3-10.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_opcode = OP_SUB; req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1; req1_opcode = OP_SUB; req1_a = 32'd3;  req1_b = 32'd10;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    rst_n = 1'b1;

    ops = 0; guard = 0; last_acc = 0; expect_id = 1'b0;
    while (ops < 6 && guard < 100) begin
      tick(a0, a1);
      guard++;
      if (a0 || a1) begin
        chk("rr_grant", 32'(a1), 32'(expect_id));
        expect_id = ~expect_id;
        if (ops > 0) chk("rr_period", 32'(cyc - last_acc), 32'(ADDSUB_CYCLES + 2));
        last_acc = cyc;
        ops++;
        if (a0) req0_a = req0_a + 32'd17;
        else    req1_b = req1_b + 32'd5;
      end
    end
    if (ops < 6) chk("rr_timeout", 32'(ops), 32'd6);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Single ADD on req0, then req0 alone again while req1 idles.
    send(1'b0, OP_ADD, 32'h0000_0005, 32'h0000_0003, 1'b1);
    chk("add_resp1_quiet", 32'(resp1_valid), 32'd0);
    drain();
    send(1'b0, OP_SUB, 32'd20, 32'd5, 1'b1);
    drain();

    // Pointer now favours req1 on a tie.
    req0_opcode = OP_ADD; req0_a = 32'd100; req0_b = 32'd1;  req0_valid = 1'b1;
    req1_opcode = OP_SUB; req1_a = 32'd50;  req1_b = 32'd8;  req1_valid = 1'b1;
    grant_wait(a0, a1);
    chk("tie_grants_req1", 32'(a1), 32'd1);
    req1_valid = 1'b0;
    grant_wait(a0, a1);
    chk("then_req0", 32'(a0), 32'd1);
    req0_valid = 1'b0;
    drain();

    // Multicycle MUL on req1; low 32 bits of 2^32 are zero.
    send(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
    drain();
    send(1'b1, OP_MUL, 32'h0000_1234, 32'h0000_0100, 1'b1);
    drain();

    // Backpressure with A == B; req1 must wait for the response handshake.
    resp0_ready = 1'b0;
    send(1'b0, OP_ADD, 32'h1234_5678, 32'h1234_5678, 1'b1);
    guard = 0;
    while (!resp0_valid && guard < 20) begin
      tick(a0, a1);
      guard++;
    end
    chk("bp_resp_valid", 32'(resp0_valid), 32'd1);
    req1_opcode = OP_ADD; req1_a = 32'd1; req1_b = 32'd2; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(a0, a1);
      chk("bp_no_grant", 32'(req1_ready), 32'd0);
      chk("bp_result", resp0_result, 32'h2468_ACF0);
      chk("bp_equal", 32'(resp0_equal), 32'd1);
    end
    resp0_ready = 1'b1;
    grant_wait(a0, a1);
    chk("bp_then_req1", 32'(a1), 32'd1);
    req1_valid = 1'b0;
    drain();

    // Illegal opcode with equal operands: ALU poison and equal must be masked.
    send(1'b0, 7'h7F, 32'h0000_0055, 32'h0000_0055, 1'b1);
    drain();

    // Reset in the middle of a MUL (pointer currently favours req1).
    send(1'b0, OP_MUL, 32'd7, 32'd9, 1'b1);
    tick(a0, a1);
    tick(a0, a1);
    rst_n = 1'b0;
    #1;
    check_zero();
    sb.delete();
    prev_rv = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(a0, a1);
      chk("no_resp_after_rst", 32'(resp0_valid | resp1_valid), 32'd0);
    end
    req0_opcode = OP_ADD; req0_a = 32'd4; req0_b = 32'd4; req0_valid = 1'b1;
    req1_opcode = OP_ADD; req1_a = 32'd6; req1_b = 32'd1; req1_valid = 1'b1;
    grant_wait(a0, a1);
    chk("rst_ptr_req0", 32'(a0), 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
